fifo_sync: RTL and testbench



---
 rtl/fifo_sync_pkg.sv | 16 +
 rtl/fifo_sync.sv | 99 +++++++++
 tb/tb_fifo_sync.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_pkg.sv
// ============================================================================
// Module   : fifo_sync_pkg
// Purpose  : Shared audio sample-width constants for the sample buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_sync_pkg;

  localparam int unsigned C_AUDIO_CH_W     = 24;
  // One stereo pair {left, right} per FIFO word.
  localparam int unsigned C_AUDIO_SAMPLE_W = 2 * C_AUDIO_CH_W;

endpackage

`default_nettype wire

// File: rtl/fifo_sync.sv
// ============================================================================
// Module   : fifo_sync
// Purpose  : Single-clock first-word-fall-through FIFO, valid/ready on both
//            sides, occupancy reported on each side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_sync
  import fifo_sync_pkg::*;
#(
  parameter int NB = C_AUDIO_SAMPLE_W,
  parameter int M  = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [NB-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [M:0]    in_count,
  output logic [NB-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M:0]    out_count
);

  localparam int unsigned C_DEPTH = 1 << M;
  localparam logic [M:0]  C_FULL  = {1'b1, {M{1'b0}}};

  logic [NB-1:0] r_mem [C_DEPTH];
  logic [M-1:0]  r_wr_ptr;
  logic [M-1:0]  r_rd_ptr;
  logic [M:0]    r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  assign w_full    = (r_count == C_FULL);
  assign w_empty   = (r_count == '0);

  assign in_ready  = !reset && !w_full;
  assign out_valid = !reset && !w_empty;
  assign w_push    = in_valid  && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign out_data  = r_mem[r_rd_ptr];
  // Both counts mirror one register so a dual-clock variant can split them later.
  assign in_count  = reset ? '0 : r_count;
  assign out_count = reset ? '0 : r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + M'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + M'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (M+1)'(1);
        2'b01:   r_count <= r_count - (M+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifndef SYNTHESIS
  logic [M-1:0] w_ptr_diff;
  assign w_ptr_diff = r_wr_ptr - r_rd_ptr;

  always @(posedge clk) begin
    if (!reset) begin
      assert (r_count <= C_FULL)
        else $error("fifo_sync: occupancy above depth");
      assert (!(in_valid && in_ready && w_full))
        else $error("fifo_sync: push while full");
      assert (!(out_valid && out_ready && w_empty))
        else $error("fifo_sync: pop while empty");
      assert (w_ptr_diff == r_count[M-1:0])
        else $error("fifo_sync: pointer distance disagrees with occupancy");
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_sync.sv
// ============================================================================
// Module   : tb_fifo_sync
// Purpose  : Self-checking bench for fifo_sync against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_sync;

  localparam int NB    = 48;
  localparam int M     = 2;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset;
  logic [NB-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [M:0]    in_count;
  logic [NB-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [M:0]    out_count;

  int total = 0;
  int bad   = 0;

  logic [NB-1:0] q[$];

  fifo_sync #(.NB(NB), .M(M)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_count  (in_count),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  // Reference model: a word is accepted when there is room, taken when there is one.
  task automatic tick();
    bit push;
    bit pop;
    push = !reset && in_valid  && (q.size() < DEPTH);
    pop  = !reset && out_ready && (q.size() > 0);
    @(posedge clk);
    if (reset) begin
      q.delete();
    end else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(in_data);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || in_count !== 3'd0 || out_count !== 3'd0) begin
        bad++;
        $display("FAIL reset_hold: got rdy=%b vld=%b ic=%0d oc=%0d want 0 0 0 0",
                 in_ready, out_valid, in_count, out_count);
      end
    end
    reset = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || in_count !== 3'd0 || out_count !== 3'd0) begin
      bad++;
      $display("FAIL reset_release: got rdy=%b vld=%b ic=%0d oc=%0d want 1 0 0 0",
               in_ready, out_valid, in_count, out_count);
    end
  endtask

  task automatic test_fill_full();
    logic [NB-1:0] w [4];
    w[0] = 48'h000001_000002; w[1] = 48'h000003_000004;
    w[2] = 48'h000005_000006; w[3] = 48'h000007_000008;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = w[i];
      tick();
      total++;
      if (in_count !== 3'(i + 1) || out_count !== 3'(i + 1)) begin
        bad++;
        $display("FAIL fill_count: got ic=%0d oc=%0d want %0d", in_count, out_count, i + 1);
      end
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL fill_full_ready: got %b want 0", in_ready);
    end
    in_data = 48'hDEAD00_BEEF00;
    tick();
    total++;
    if (in_count !== 3'd4 || out_data !== 48'h000001_000002 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL fill_hold5: got ic=%0d data=%h vld=%b want 4 000001000002 1",
               in_count, out_data, out_valid);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_drain();
    logic [NB-1:0] w [4];
    w[0] = 48'h000001_000002; w[1] = 48'h000003_000004;
    w[2] = 48'h000005_000006; w[3] = 48'h000007_000008;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (out_valid !== 1'b1 || out_data !== w[i]) begin
        bad++;
        $display("FAIL drain_data[%0d]: got vld=%b data=%h want 1 %h", i, out_valid, out_data, w[i]);
      end
      tick();
      total++;
      if (out_count !== 3'(3 - i) || (i == 0 && in_ready !== 1'b1)) begin
        bad++;
        $display("FAIL drain_count[%0d]: got oc=%0d rdy=%b want %0d 1", i, out_count, in_ready, 3 - i);
      end
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain_empty: got vld=%b want 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [NB-1:0] w [12];
    for (int i = 0; i < 12; i++) w[i] = 48'h00A000_000100 + 48'(i);
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = w[i];
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = w[i + 2];
      #1;
      total++;
      if (out_data !== w[i] || out_count !== 3'd2 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b[%0d]: got data=%h oc=%0d rdy=%b want %h 2 1",
                 i, out_data, out_count, in_ready, w[i]);
      end
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8 && q.size() > 0; i++) tick();
    total++;
    if (out_valid !== 1'b0 || out_count !== 3'd0) begin
      bad++;
      $display("FAIL b2b_drain: got vld=%b oc=%0d want 0 0", out_valid, out_count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_empty_push_pop();
    in_valid = 1'b1; out_ready = 1'b1; in_data = 48'h135791_24680A;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    total++;
    if (in_count !== 3'd1 || out_valid !== 1'b1 || out_data !== 48'h135791_24680A) begin
      bad++;
      $display("FAIL empty_pushpop: got ic=%0d vld=%b data=%h want 1 1 13579124680a",
               in_count, out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 48'h777000_000000 + 48'(i);
      tick();
    end
    in_valid = 1'b0;
    total++;
    if (in_count !== 3'd3) begin
      bad++;
      $display("FAIL midrst_pre: got ic=%0d want 3", in_count);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (in_count !== 3'd0 || out_count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrst_post: got ic=%0d oc=%0d vld=%b rdy=%b want 0 0 0 1",
               in_count, out_count, out_valid, in_ready);
    end
    in_valid = 1'b1; in_data = 48'hABCDEF_123456;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 48'hABCDEF_123456 || out_count !== 3'd1) begin
      bad++;
      $display("FAIL midrst_push: got vld=%b data=%h oc=%0d want 1 abcdef123456 1",
               out_valid, out_data, out_count);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [63:0] r;
    int          exp_n;
    for (int i = 0; i < 600; i++) begin
      // Alternate bias so runs reach both full and empty often.
      if ((i / 100) % 2 == 0) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) == 0);
      end else begin
        in_valid  = ($urandom_range(0, 2) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end
      r       = {$urandom, $urandom};
      in_data = r[NB-1:0];
      reset   = ($urandom_range(0, 79) == 0);
      #1;
      exp_n = reset ? 0 : q.size();
      total++;
      if (in_ready !== (!reset && q.size() < DEPTH) || out_valid !== (!reset && q.size() > 0)
          || in_count !== 3'(exp_n) || out_count !== 3'(exp_n)) begin
        bad++;
        $display("FAIL rand_ctl[%0d]: got rdy=%b vld=%b ic=%0d oc=%0d want occupancy %0d rst=%b",
                 i, in_ready, out_valid, in_count, out_count, exp_n, reset);
      end
      if (!reset && q.size() > 0) begin
        total++;
        if (out_data !== q[0]) begin
          bad++;
          $display("FAIL rand_data[%0d]: got %h want %h", i, out_data, q[0]);
        end
      end
      tick();
    end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    test_reset();
    test_fill_full();
    test_drain();
    test_back_to_back();
    test_empty_push_pop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
